// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds WIDTH-bit operands CHUNK bits per clock, LSB slice first.
// Optional subtract mode (port sub) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] ra, rb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] sa, sb;
  logic [CHUNK:0]   part;
  logic             last, accept, sub_i;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  always_comb begin
    accept  = start && state != RUN;
    last    = idx == IW'(N - 1);
    busy    = state == RUN;
    done    = state == DONE;
    state_n = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
  end
  always_comb begin
    sa   = CHUNK'(ra >> (idx * CHUNK));
    sb   = CHUNK'(rb >> (idx * CHUNK));
    part = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, carry};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  // carry into the MSB equals a^b^sum at that bit, so ovf needs no extra adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= sub_i ? ~b : b;
      carry <= sub_i | cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[idx*CHUNK +: CHUNK] <= part[CHUNK-1:0];
      carry <= part[CHUNK];
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout <= part[CHUNK];
        ovf  <= sa[CHUNK-1] ^ sb[CHUNK-1] ^ part[CHUNK-1] ^ part[CHUNK];
      end
    end
  end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed vector table plus multi-cycle sequences for serial_chunk_adder.
module tb_serial_chunk_adder;
  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub = 1'b0, sub8 = 1'b0;
`endif
  int checks = 0, failures = 0;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       c, s;
    logic [7:0] es;
    logic       ec, eo;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [7:0] ta, tb_, input logic tc, ts,
                    output logic [7:0] rs, output logic rc, ro, output int lat);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) $display("sub vector skipped in add-only build");
`endif
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ~ts;
`endif
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc, ro, seen;
    int         lat, k, e;
    v.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    v.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    v.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    v.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0});
    v.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    v.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
    v.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
    v.push_back('{8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1});
    v.push_back('{8'hC0, 8'hBF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    v.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    v.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
    v.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {busy, done, cout, ovf, sum}, 0);
    chk("reset_outputs8", {busy8, done8, cout8, ovf8, sum8}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      op(v[i].a, v[i].b, v[i].c, v[i].s, rs, rc, ro, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_sum", i), rs, v[i].es);
      chk($sformatf("v%0d_cout", i), rc, v[i].ec);
      chk($sformatf("v%0d_ovf", i), ro, v[i].eo);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {busy, done}, 0);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_hold", i), {cout, ovf, sum}, {v[i].ec, v[i].eo, v[i].es});
    end

    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      a = 8'(j * 17 + 3); b = 8'(j * 29 + 11); cin = j[0]; start = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("b2b_done_%0d", j), done, (j % 5) == 4);
      chk($sformatf("b2b_busy_%0d", j), busy, (j % 5) != 4);
      if (j % 5 == 4) begin
        k = j - 4;
        e = ((k * 17 + 3) & 255) + ((k * 29 + 11) & 255) + (k & 1);
        chk($sformatf("b2b_sum_%0d", j), {cout, sum}, e[8:0]);
      end
    end
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_idle", {busy, done}, 0);

    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_run_outputs", {busy, done, cout, ovf, sum}, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("rst_run_no_done", seen, 0);
    op(8'h55, 8'h22, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("rst_fresh_latency", lat, 4);
    chk("rst_fresh_result", {rc, ro, rs}, {2'b00, 8'h77});

    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
    chk("c8_busy", {busy8, done8}, 2'b10);
    @(posedge clk); #1;
    chk("c8_done", {busy8, done8}, 2'b01);
    chk("c8_result", {cout8, ovf8, sum8}, {2'b00, 8'h47});
    @(posedge clk); #1;
    chk("c8_idle", {busy8, done8, sum8}, {2'b00, 8'h47});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 2: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new addition; sampled only when not busy.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  single-cycle pulse when the result is valid.
REQ-011 sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-012 cout  output  1  carry-out of bit WIDTH-1.
REQ-013 ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR cout.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after the last chunk.
- DONE->RUN if start=1, else DONE->IDLE.
REQ-015 On accepted start, the block SHALL latch a, b and cin into internal registers and clear the chunk index; later input changes SHALL NOT affect the operation.
REQ-016 Each RUN cycle SHALL add one CHUNK-bit slice, LSB slice first, using the registered carry from the previous slice, and write that slice of sum.
REQ-017 A RUN phase SHALL last exactly WIDTH/CHUNK cycles; the chunk index SHALL wrap to 0 on exit.
REQ-018 Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH/CHUNK.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 done SHALL be 1 only in DONE. cout and ovf SHALL update in the same edge that enters DONE.
REQ-021 start while busy=1 SHALL be ignored with no queueing.
REQ-022 start in the DONE cycle SHALL be accepted. Back-to-back operations SHALL have no idle gap.
REQ-023 CHUNK=WIDTH SHALL be a legal configuration giving one RUN cycle.
REQ-024 sum, cout and ovf SHALL retain their last values in IDLE.

Reset
REQ-025 rst_n=0 SHALL, with no clock edge:
- force state to IDLE;
- set busy=0, done=0, sum=0, cout=0, ovf=0;
- clear the latched operands, carry and chunk index.
REQ-026 Reset during RUN SHALL abandon the operation, with no done pulse after release.
REQ-027 After rst_n rises, the first start SHALL be accepted on the first clock edge.

Configuration
REQ-028 Macro SERIAL_ADDER_SUB_EN defined: adds input port sub (1 bit, sampled with start).
- If sub=1, the block SHALL latch ~b and force the carry-in to 1, computing a-b-(0), and ignore cin.
- cout SHALL then mean no-borrow.
REQ-029 Macro undefined: no sub port; the block is addition only with identical timing.

Verification (WIDTH=8, CHUNK=2 unless stated)
REQ-030 a=0xFF, b=0x01, cin=0, start pulse -> done 4 cycles later, sum=0x00, cout=1, ovf=0.
REQ-031 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-032 start held high continuously, operands changed each cycle -> the new operation is accepted only at the DONE cycle, done pulses every 5 cycles, and each sum matches the operands latched at its start.
REQ-033 rst_n pulled low 2 cycles into RUN -> all outputs 0 immediately, no done pulse; a fresh start after release gives the correct result.
REQ-034 CHUNK=8, a=0x12, b=0x34, cin=1 -> done after 1 RUN cycle, sum=0x47, cout=0.
REQ-035 With SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. Also a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
